serial_t: RTL and testbench
===========================

Name: serial_t

Overview:
- 8N1 UART transmitter: one start bit, eight data bits LSB first, one stop bit, no parity.
- Accepts a byte with a one-cycle `send` strobe and serialises it on `tx` at a fixed clocks-per-bit rate.
- Sits between the on-board controller logic and the USB-serial bridge pin of the 50 MHz base design.
- `block` lets the downstream bridge stall new transmissions.

Parameters:
- CLK_PER_BIT, default 50, number of `clk` cycles each serial bit is held (50 MHz / 50 = 1 Mbaud). Minimum legal value is 2.
- CTR_SIZE, default 6, width of the bit-period counter. Must satisfy 2^CTR_SIZE >= CLK_PER_BIT.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  reset; synchronous and active-high.
- tx  output  1  serial line, idle high. Driven from a register, glitch-free.
- block  input  1  when high, no new frame may start.
- busy  output  1  high while a frame is in progress or `block` is asserted. Registered.
- data  input  8  byte to send. Sampled only on the accepting edge.
- send  input  1  transmit request strobe.

Behaviour:
- State machine: IDLE, START_BIT, DATA, STOP_BIT. Registers are the state, a bit-period counter (CTR_SIZE bits), a bit index (3 bits), a data shift/hold register (8 bits), `tx_q` and `busy_q`.
- Reset (rst=1 at a rising edge):
  - state=IDLE, counter=0, bit index=0, tx=1, busy=0.
  - Reset takes effect from any state. A frame in progress is aborted and `tx` returns high on the next cycle.
- IDLE:
  - tx=1.
  - busy = value of `block` registered, i.e. one-cycle latency.
  - If send=1 and block=0 at a rising edge: latch `data`, clear counter and bit index, go to START_BIT, busy=1 from the next cycle.
  - If send=1 and block=1: the request is ignored (not queued).
- START_BIT:
  - tx=0 for exactly CLK_PER_BIT cycles.
  - When counter reaches CLK_PER_BIT-1: clear counter, go to DATA.
- DATA:
  - tx = latched data[bit index], index 0 first, each bit held CLK_PER_BIT cycles.
  - At period end: clear counter. If index=7, go to STOP_BIT; otherwise increment index.
- STOP_BIT:
  - tx=1 for CLK_PER_BIT cycles.
  - At period end: go to IDLE; busy follows `block` from then on.
- Latency and frame length:
  - The first start-bit cycle on `tx` is the cycle immediately after the accepting edge.
  - A full frame is 10*CLK_PER_BIT cycles.
  - busy=1 for the entire frame, including the stop bit.
- `send` during a frame (busy=1) is ignored. `data` changes during a frame do not affect the frame.
- Back-to-back frames: a `send` on the first IDLE cycle after STOP_BIT is accepted. The minimum inter-frame gap is one idle cycle with tx=1.
- `block` asserted mid-frame does not abort or stretch the frame. After the stop bit the block stays in IDLE with busy=1 until `block` deasserts.
- Simultaneous rst and send: reset wins; no frame starts.

Test Plan:
- Reset: rst=1 for 5 cycles, send=0 -> tx=1, busy=0 after the first reset edge; both hold after rst falls.
- Single frame: after reset, data=8'hAA, send=1 for one cycle -> busy=1 from the next cycle. tx sequence is 0 | 0,1,0,1,0,1,0,1 | 1, each bit 50 cycles. busy=0 exactly 500 cycles after acceptance.
- Ignore while busy: start 8'h55, then pulse send with data=8'hFF at cycle 100 of the frame -> the frame still transmits 0x55 bits (1,0,1,0,1,0,1,0) and no second frame follows.
- Block: block=1 and a send pulse in IDLE -> tx stays 1, busy=1 one cycle later. Drop block -> busy=0 next cycle. A fresh send then transmits normally.
- Block mid-frame: assert block during DATA of 8'h0F -> the frame completes unchanged, and busy stays 1 after the stop bit until block=0.
- Reset mid-frame: assert rst during DATA bit 3 -> next cycle tx=1, busy=0, state IDLE. A subsequent send of 8'h01 transmits a correct full frame.

Source files
------------

// File: rtl/serial_t.sv
// 8N1 UART transmitter: start bit, eight data bits LSB first, stop bit.
// tx and busy are both registered; the first start-bit cycle follows the accepting edge.
module serial_t #(
  parameter int CLK_PER_BIT = 50,
  parameter int CTR_SIZE    = 6
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tx,
  input  logic       block,
  output logic       busy,
  input  logic [7:0] data,
  input  logic       send
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA      = 2'd2,
    STOP_BIT  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CTR_SIZE-1:0] ctr_q, ctr_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          data_q, data_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                period_end;

  assign period_end = (ctr_q == CTR_SIZE'(CLK_PER_BIT - 1));
  assign tx         = tx_q;
  assign busy       = busy_q;

  // tx_d is derived from the state being entered so tx lines up with that state's first cycle.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    idx_d   = idx_q;
    data_d  = data_q;
    tx_d    = tx_q;
    busy_d  = 1'b1;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = block;
        if (send && !block) begin
          data_d  = data;
          ctr_d   = '0;
          idx_d   = 3'd0;
          state_d = START_BIT;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START_BIT: begin
        if (period_end) begin
          ctr_d   = '0;
          state_d = DATA;
          tx_d    = data_q[0];
        end else begin
          ctr_d = ctr_q + CTR_SIZE'(1);
          tx_d  = 1'b0;
        end
      end
      DATA: begin
        if (period_end) begin
          ctr_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP_BIT;
            tx_d    = 1'b1;
          end else begin
            // Shift so the bit on the line is always data_q[0].
            idx_d  = idx_q + 3'd1;
            data_d = {1'b0, data_q[7:1]};
            tx_d   = data_q[1];
          end
        end else begin
          ctr_d = ctr_q + CTR_SIZE'(1);
          tx_d  = data_q[0];
        end
      end
      STOP_BIT: begin
        tx_d = 1'b1;
        if (period_end) begin
          ctr_d   = '0;
          state_d = IDLE;
          busy_d  = block;
        end else begin
          ctr_d = ctr_q + CTR_SIZE'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      idx_q   <= 3'd0;
      data_q  <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_serial_t.sv
// Directed bench for serial_t at CLK_PER_BIT=50: frame shape, busy timing, block, ignore and reset cases.
module tb_serial_t;

  localparam int CPB = 50;

  logic       clk;
  logic       rst;
  logic       tx;
  logic       block;
  logic       busy;
  logic [7:0] data;
  logic       send;

  int total = 0;
  int bad   = 0;

  serial_t #(.CLK_PER_BIT(CPB), .CTR_SIZE(6)) dut (
    .clk  (clk),
    .rst  (rst),
    .tx   (tx),
    .block(block),
    .busy (busy),
    .data (data),
    .send (send)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock; observations and new inputs happen 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse send for one edge; on return we are in the first start-bit cycle.
  task automatic accept(input logic [7:0] b);
    data = b;
    send = 1'b1;
    tick();
    send = 1'b0;
    data = 8'hC3;
  endtask

  // Walks frame cycles 0..499 after acceptance, checking tx at the first and last
  // cycle of every bit and busy at the first cycle. Optional mid-frame pokes.
  task automatic watch_frame(input logic [7:0] b, input string nm,
                             input int poke_at, input logic [7:0] poke_data,
                             input int block_at);
    logic exp_tx;
    int   bitn;
    for (int i = 0; i < 10 * CPB; i++) begin
      bitn = i / CPB;
      if (bitn == 0)      exp_tx = 1'b0;
      else if (bitn == 9) exp_tx = 1'b1;
      else                exp_tx = b[bitn - 1];
      if ((i % CPB == 0) || (i % CPB == CPB - 1)) begin
        total++;
        if (tx !== exp_tx) begin
          bad++;
          $display("FAIL %s tx cycle %0d bit %0d: got %b want %b", nm, i, bitn, tx, exp_tx);
        end
      end
      if (i % CPB == 0) begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL %s busy cycle %0d: got %b want 1", nm, i, busy);
        end
      end
      if (i == poke_at) begin
        send = 1'b1;
        data = poke_data;
      end else begin
        send = 1'b0;
      end
      if (i == block_at) block = 1'b1;
      tick();
    end
    send = 1'b0;
    $display("frame %s byte %h observed", nm, b);
  endtask

  task automatic test_reset();
    rst = 1'b1; send = 1'b0; block = 1'b0; data = 8'h00;
    tick();
    total++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_first_edge: got tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
    repeat (4) tick();
    rst = 1'b0;
    repeat (3) tick();
    total++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold: got tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_single_frame();
    accept(8'hAA);
    watch_frame(8'hAA, "single_AA", -1, 8'h00, -1);
    total++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      bad++;
      $display("FAIL single_end_500: got busy=%b tx=%b want busy=0 tx=1", busy, tx);
    end
    repeat (10) tick();
    total++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_idle_after: got tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
  endtask

  task automatic test_ignore_busy();
    accept(8'h55);
    watch_frame(8'h55, "ignore_55", 100, 8'hFF, -1);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_end_busy: got %b want 0", busy);
    end
    for (int i = 0; i < 60; i++) begin
      if (i == 1 || i == 30 || i == 55) begin
        total++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
          bad++;
          $display("FAIL ignore_no_second_frame idle cycle %0d: got tx=%b busy=%b want tx=1 busy=0", i, tx, busy);
        end
      end
      tick();
    end
  endtask

  task automatic test_block_idle();
    block = 1'b1;
    data  = 8'h33;
    send  = 1'b1;
    tick();
    send = 1'b0;
    total++;
    if (busy !== 1'b1 || tx !== 1'b1) begin
      bad++;
      $display("FAIL block_idle_first: got busy=%b tx=%b want busy=1 tx=1", busy, tx);
    end
    repeat (20) tick();
    total++;
    if (busy !== 1'b1 || tx !== 1'b1) begin
      bad++;
      $display("FAIL block_idle_hold: got busy=%b tx=%b want busy=1 tx=1", busy, tx);
    end
    block = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL block_release: got busy=%b want 0", busy);
    end
    accept(8'h33);
    watch_frame(8'h33, "after_block_33", -1, 8'h00, -1);
    $display("test_block_idle done");
  endtask

  task automatic test_back_to_back();
    accept(8'h96);
    watch_frame(8'h96, "b2b_first_96", -1, 8'h00, -1);
    // First idle cycle: tx must be high, and a send here is accepted.
    total++;
    if (tx !== 1'b1) begin
      bad++;
      $display("FAIL b2b_gap_tx: got %b want 1", tx);
    end
    accept(8'h3C);
    watch_frame(8'h3C, "b2b_second_3C", -1, 8'h00, -1);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_block_midframe();
    accept(8'h0F);
    watch_frame(8'h0F, "blockmid_0F", -1, 8'h00, 120);
    total++;
    if (busy !== 1'b1 || tx !== 1'b1) begin
      bad++;
      $display("FAIL blockmid_after_stop: got busy=%b tx=%b want busy=1 tx=1", busy, tx);
    end
    send = 1'b1;
    data = 8'h00;
    tick();
    send = 1'b0;
    repeat (5) tick();
    total++;
    if (busy !== 1'b1 || tx !== 1'b1) begin
      bad++;
      $display("FAIL blockmid_held: got busy=%b tx=%b want busy=1 tx=1", busy, tx);
    end
    block = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      bad++;
      $display("FAIL blockmid_release: got busy=%b tx=%b want busy=0 tx=1", busy, tx);
    end
  endtask

  task automatic test_reset_midframe();
    accept(8'hA5);
    // Bit 3 occupies frame cycles 200..249; A5 bit 3 is 0.
    repeat (210) tick();
    total++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_before: got tx=%b busy=%b want tx=0 busy=1", tx, busy);
    end
    rst = 1'b1;
    tick();
    total++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_abort: got tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
    rst = 1'b0;
    repeat (3) tick();
    total++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_idle: got tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
    accept(8'h01);
    watch_frame(8'h01, "rstmid_01", -1, 8'h00, -1);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_frame_end: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_rst_and_send();
    rst  = 1'b1;
    send = 1'b1;
    data = 8'h00;
    tick();
    rst  = 1'b0;
    send = 1'b0;
    total++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_send_edge: got tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
    repeat (5) tick();
    total++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_send_no_frame: got tx=%b busy=%b want tx=1 busy=0", tx, busy);
    end
    $display("test_rst_and_send done");
  endtask

  initial begin
    rst = 1'b1; send = 1'b0; block = 1'b0; data = 8'h00;
    test_reset();
    test_single_frame();
    test_ignore_busy();
    test_block_idle();
    test_back_to_back();
    test_block_midframe();
    test_reset_midframe();
    test_rst_and_send();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
